twi_frame_monitor: RTL and testbench

- Passive TWI/I2C bus decoder fed by already-synchronized SCL/SDA levels, one two-stage synchronizer per line upstream.
- Detects START, repeated START and STOP; shifts in 8-bit bytes plus ACK; presents each completed byte on a valid/ready output with a 1-entry holding register.
- Sequences frame state (address byte vs data bytes), counts bytes per frame, and flags overruns and aborted bytes for the monitor's reporting logic downstream.

---
 rtl/twi_frame_monitor_pkg.sv | 17 +
 rtl/twi_frame_monitor_if.sv | 16 +
 rtl/twi_frame_monitor_edge_detect.sv | 28 ++
 rtl/twi_frame_monitor.sv | 164 ++++++++++++++++
 tb/tb_twi_frame_monitor.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/twi_frame_monitor_pkg.sv
// Shared types and constants for the TWI frame monitor.
package twi_mon_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, IGNORE} state_t;

    localparam int BITS_PER_BYTE = 8;
    localparam int ACK_BIT_IDX   = 8;
    localparam int IDX_W         = 16;  // widest byte index a record can carry

    typedef struct packed {
        logic [BITS_PER_BYTE-1:0] data;
        logic                     is_addr;
        logic                     ack;
        logic [IDX_W-1:0]         index;
    } byte_rec_t;

endpackage

// File: rtl/twi_frame_monitor_if.sv
// Byte output channel: valid/ready handshake plus the decoded byte fields.
interface twi_frame_monitor_if #(
    parameter int CNT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_is_addr;
    logic             out_ack;
    logic [CNT_W-1:0] out_index;

    modport master (output out_valid, out_data, out_is_addr, out_ack, out_index,
                    input  out_ready);
    modport slave  (input  out_valid, out_data, out_is_addr, out_ack, out_index,
                    output out_ready);
endinterface

// File: rtl/twi_frame_monitor_edge_detect.sv
// Bus condition decoder: SCL rising edge, START and STOP from registered levels.
module twi_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic rise_scl,
    output logic start,
    output logic stop
);
    logic scl_q, sda_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_in;
            sda_q <= sda_in;
        end
    end

    // START/STOP need SCL high on both samples, so a simultaneous SCL/SDA
    // change while SCL was low only ever reads as a clock edge.
    assign rise_scl = !scl_q & scl_in;
    assign start    = scl_q & scl_in & sda_q & !sda_in;
    assign stop     = scl_q & scl_in & !sda_q & sda_in;
endmodule

// File: rtl/twi_frame_monitor.sv
// Passive TWI frame decoder with a 1-entry byte output register.
// Optional address filtering is enabled by defining TWI_ADDR_FILTER_EN.
module twi_frame_monitor
    import twi_mon_pkg::*;
#(
    parameter int CNT_W = 8
`ifdef TWI_ADDR_FILTER_EN
    , parameter logic [6:0] MATCH_ADDR = 7'h50
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scl_in,
    input  logic                sda_in,
    input  logic                clr_flags,
    twi_frame_monitor_if.master out_if,
    output logic                start_pulse,
    output logic                stop_pulse,
    output logic                bus_busy,
    output logic                overrun,
    output logic                abort
);
    localparam int BC_W = $clog2(ACK_BIT_IDX + 1);

    logic rise_scl, start_det, stop_det;

    twi_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .rise_scl (rise_scl),
        .start    (start_det),
        .stop     (stop_det)
    );

    state_t                   state, state_nx;
    logic [BC_W-1:0]          bit_cnt, bit_cnt_nx;
    logic [CNT_W-1:0]         byte_cnt, byte_cnt_nx;
    logic                     first, first_nx;
    logic [BITS_PER_BYTE-1:0] shreg, shreg_nx;
    logic                     complete, start_evt, stop_evt, abort_set;

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        byte_cnt_nx = byte_cnt;
        first_nx    = first;
        shreg_nx    = shreg;
        complete    = 1'b0;
        start_evt   = 1'b0;
        stop_evt    = 1'b0;
        abort_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_det) begin
                    state_nx    = ACTIVE;
                    bit_cnt_nx  = '0;
                    byte_cnt_nx = '0;
                    first_nx    = 1'b1;
                    start_evt   = 1'b1;
                end else if (stop_det) begin
                    stop_evt = 1'b1;
                end
            end
            ACTIVE: begin
                if (start_det) begin
                    abort_set   = (bit_cnt != '0);
                    bit_cnt_nx  = '0;
                    byte_cnt_nx = '0;
                    first_nx    = 1'b1;
                    start_evt   = 1'b1;
                end else if (stop_det) begin
                    abort_set  = (bit_cnt != '0);
                    bit_cnt_nx = '0;
                    stop_evt   = 1'b1;
                    state_nx   = IDLE;
                end else if (rise_scl) begin
                    if (bit_cnt == BC_W'(ACK_BIT_IDX)) begin
                        complete    = 1'b1;
                        bit_cnt_nx  = '0;
                        first_nx    = 1'b0;
                        byte_cnt_nx = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;
`ifdef TWI_ADDR_FILTER_EN
                        if (first && (shreg[7:1] != MATCH_ADDR)) begin
                            complete = 1'b0;
                            state_nx = IGNORE;
                        end
`endif
                    end else begin
                        shreg_nx   = {shreg[BITS_PER_BYTE-2:0], sda_in};
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef TWI_ADDR_FILTER_EN
            IGNORE: begin
                if (start_det) begin
                    state_nx    = ACTIVE;
                    bit_cnt_nx  = '0;
                    byte_cnt_nx = '0;
                    first_nx    = 1'b1;
                    start_evt   = 1'b1;
                end else if (stop_det) begin
                    state_nx = IDLE;
                    stop_evt = 1'b1;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            bit_cnt            <= '0;
            byte_cnt           <= '0;
            first              <= 1'b0;
            shreg              <= '0;
            start_pulse        <= 1'b0;
            stop_pulse         <= 1'b0;
            bus_busy           <= 1'b0;
            overrun            <= 1'b0;
            abort              <= 1'b0;
            out_if.out_valid   <= 1'b0;
            out_if.out_data    <= '0;
            out_if.out_is_addr <= 1'b0;
            out_if.out_ack     <= 1'b0;
            out_if.out_index   <= '0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            byte_cnt    <= byte_cnt_nx;
            first       <= first_nx;
            shreg       <= shreg_nx;
            start_pulse <= start_evt;
            stop_pulse  <= stop_evt;
            bus_busy    <= (state_nx != IDLE);

            // A completed byte replaces the held one only if the slot frees up
            // this cycle; otherwise the newcomer is dropped.
            if (complete && (!out_if.out_valid || out_if.out_ready)) begin
                out_if.out_valid   <= 1'b1;
                out_if.out_data    <= shreg;
                out_if.out_is_addr <= first;
                out_if.out_ack     <= !sda_in;
                out_if.out_index   <= byte_cnt;
            end else if (out_if.out_valid && out_if.out_ready) begin
                out_if.out_valid <= 1'b0;
            end

            if (complete && out_if.out_valid && !out_if.out_ready)
                overrun <= 1'b1;
            else if (clr_flags)
                overrun <= 1'b0;

            if (abort_set)
                abort <= 1'b1;
            else if (clr_flags)
                abort <= 1'b0;
        end
    end
endmodule

// File: tb/tb_twi_frame_monitor.sv
// Bench for twi_frame_monitor: directed frame table, corner sequences and random frames.
module tb_twi_frame_monitor;
    import twi_mon_pkg::*;

    logic clk = 1'b0;
    logic reset, scl, sda, clr_flags;
    logic start_pulse, stop_pulse, bus_busy, overrun, abort;
    logic fixed_ready = 1'b1;
    logic rand_ready  = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int n_start = 0;
    int n_stop = 0;

    byte_rec_t got[$];
    byte_rec_t exp_q[$];
    logic [7:0] fb[$];
    logic       fa[$];

    twi_frame_monitor_if #(.CNT_W(8)) bus ();

    twi_frame_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl),
        .sda_in      (sda),
        .clr_flags   (clr_flags),
        .out_if      (bus),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .bus_busy    (bus_busy),
        .overrun     (overrun),
        .abort       (abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    // Observer: every accepted beat and every pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                byte_rec_t r;
                r.data    = bus.out_data;
                r.is_addr = bus.out_is_addr;
                r.ack     = bus.out_ack;
                r.index   = IDX_W'(bus.out_index);
                got.push_back(r);
            end
            if (start_pulse) n_start++;
            if (stop_pulse)  n_stop++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            sda = 1'b1; cyc(2);
            scl = 1'b1; cyc(2);
        end
        sda = 1'b0; cyc(2);
        scl = 1'b0; cyc(2);
    endtask

    task automatic bus_bit(input logic b);
        sda = b;    cyc(2);
        scl = 1'b1; cyc(3);
        scl = 1'b0; cyc(2);
    endtask

    task automatic bus_stop();
        sda = 1'b0; cyc(2);
        scl = 1'b1; cyc(2);
        sda = 1'b1; cyc(3);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_bit(!ack);
    endtask

    // Reference: a frame's beats are its bytes in order, first one is the address.
    task automatic model_frame();
        logic [7:0] a;
        byte_rec_t  r;
        a = fb[0];
`ifdef TWI_ADDR_FILTER_EN
        if (a[7:1] != 7'h50) return;
`endif
        for (int i = 0; i < fb.size(); i++) begin
            r.data    = fb[i];
            r.is_addr = (i == 0);
            r.ack     = fa[i];
            r.index   = IDX_W'(i);
            exp_q.push_back(r);
        end
    endtask

    task automatic run_frame();
        bus_start();
        for (int i = 0; i < fb.size(); i++) send_byte(fb[i], fa[i]);
        bus_stop();
        model_frame();
    endtask

    task automatic compare_beats(input string nm);
        for (int i = 0; i < 200 && got.size() < exp_q.size(); i++) cyc(1);
        cyc(4);
        chk({nm, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({nm, "_beat"}, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0] b0, b1;
        logic       k0, k1;
        int         exp_n;
        logic [7:0] e_d1;
        logic       e_ack1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int s_start, s_stop, nb;
        logic [7:0] v8;

        vecs[0] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 2, 8'h3C, 1'b1};
        vecs[1] = '{8'hA0, 8'hFF, 1'b1, 1'b0, 2, 8'hFF, 1'b0};
`ifdef TWI_ADDR_FILTER_EN
        vecs[2] = '{8'hA2, 8'h55, 1'b1, 1'b1, 0, 8'h55, 1'b1};
`else
        vecs[2] = '{8'hA2, 8'h55, 1'b1, 1'b1, 2, 8'h55, 1'b1};
`endif
        vecs[3] = '{8'hA1, 8'h00, 1'b1, 1'b1, 2, 8'h00, 1'b1};

        reset = 1'b1; scl = 1'b1; sda = 1'b1; clr_flags = 1'b0;
        #12;
        chk("reset_outputs", {bus.out_valid, start_pulse, stop_pulse, bus_busy, overrun, abort,
                              bus.out_data, bus.out_is_addr, bus.out_ack, bus.out_index}, 0);
        cyc(2);
        reset = 1'b0;
        cyc(3);

        for (int v = 0; v < 4; v++) begin
            got.delete();
            s_start = n_start; s_stop = n_stop;
            bus_start();
            chk("busy_in_frame", bus_busy, 1);
            send_byte(vecs[v].b0, vecs[v].k0);
            send_byte(vecs[v].b1, vecs[v].k1);
            bus_stop();
            for (int i = 0; i < 100 && got.size() < vecs[v].exp_n; i++) cyc(1);
            cyc(4);
            chk("vec_count", got.size(), vecs[v].exp_n);
            if (got.size() == 2 && vecs[v].exp_n == 2) begin
                chk("vec_addr", {got[0].data, got[0].is_addr, got[0].ack, got[0].index},
                    {vecs[v].b0, 1'b1, vecs[v].k0, 16'd0});
                chk("vec_data", {got[1].data, got[1].is_addr, got[1].ack, got[1].index},
                    {vecs[v].e_d1, 1'b0, vecs[v].e_ack1, 16'd1});
            end
            chk("vec_start_pulses", n_start - s_start, 1);
            chk("vec_stop_pulses", n_stop - s_stop, 1);
            chk("busy_after_stop", bus_busy, 0);
            chk("vec_no_overrun", overrun, 0);
        end
        got.delete();

        // Consumer stalled across three bytes: first byte held, later ones dropped.
        fixed_ready = 1'b0; cyc(2);
        bus_start();
        send_byte(8'hA0, 1'b1);
        chk("ovr_first_held", {bus.out_valid, overrun}, 2'b10);
        send_byte(8'h11, 1'b1);
        chk("ovr_set", overrun, 1);
        chk("ovr_hold", {bus.out_data, bus.out_is_addr, bus.out_index}, {8'hA0, 1'b1, 8'd0});
        send_byte(8'h22, 1'b1);
        chk("ovr_hold2", {bus.out_valid, bus.out_data, bus.out_index}, {1'b1, 8'hA0, 8'd0});
        clr_flags = 1'b1; cyc(1); clr_flags = 1'b0; cyc(1);
        chk("ovr_cleared", overrun, 0);
        bus_stop();
        fixed_ready = 1'b1;
        fb = '{8'hA0}; fa = '{1'b1}; model_frame();
        compare_beats("ovr_drain");

        // Repeated START after 4 data bits discards them and flags abort.
        clr_flags = 1'b1; cyc(1); clr_flags = 1'b0; cyc(1);
        chk("abort_cleared", abort, 0);
        s_start = n_start;
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
        chk("abort_not_yet", abort, 0);
        bus_start();
        chk("abort_set", abort, 1);
        chk("abort_starts", n_start - s_start, 2);
        send_byte(8'h51, 1'b1);
        bus_stop();
        fb = '{8'h51}; fa = '{1'b1}; model_frame();
        compare_beats("abort_next");

        // Asynchronous reset part way through a byte with a byte held.
        fixed_ready = 1'b0; cyc(2);
        bus_start();
        send_byte(8'hA0, 1'b1);
        for (int i = 0; i < 5; i++) bus_bit(i[0]);
        chk("pre_reset_held", bus.out_valid, 1);
        #3 reset = 1'b1;
        #1;
        chk("midreset_outputs", {bus.out_valid, start_pulse, stop_pulse, bus_busy, overrun, abort,
                                 bus.out_data, bus.out_is_addr, bus.out_ack, bus.out_index}, 0);
        scl = 1'b1; sda = 1'b1;
        cyc(3);
        reset = 1'b0;
        got.delete(); exp_q.delete();
        fixed_ready = 1'b1;
        cyc(3);
        fb = '{8'hA0, 8'h5A}; fa = '{1'b1, 1'b0};
        run_frame();
        compare_beats("post_reset");

        // Random frames with a jittery consumer.
        rand_ready = 1'b1;
        for (int f = 0; f < 25; f++) begin
            fb.delete(); fa.delete();
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) begin
                v8 = 8'($urandom);
                if (i == 0 && $urandom_range(0, 1) == 1) v8 = {7'h50, v8[0]};
                fb.push_back(v8);
                fa.push_back(1'($urandom_range(0, 1)));
            end
            run_frame();
            compare_beats("rand");
        end
        chk("rand_no_overrun", overrun, 0);
        rand_ready = 1'b0;
        cyc(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
